mem_access: RTL and testbench

Memory-stage data-access unit sitting between the EX/MEM pipeline register and the `mem_wb` register. It:
- turns a load/store into a word-aligned data-memory request and holds it until `dmem_resp`;
- stalls the pipeline while the request is outstanding;
- formats load data with sign or zero extension;
- produces the rmask, wmask, address and wdata values that `mem_wb` captures for writeback and RVFI.

A small FSM guarantees exactly one memory transaction per instruction, even when the pipeline is held by another stall.

---
 rtl/mem_access_if.sv | 41 ++++
 rtl/mem_access.sv | 118 +++++++++++
 tb/tb_mem_access.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Bundle of MEM-stage pipeline, data-memory and mem_wb signals around mem_access.
// The slave modport is the access unit's view; master is the surrounding pipeline/memory.
interface mem_access_if;
   logic        valid_in;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr_in;
   logic [31:0] store_data_in;
   logic        advance;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_address;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic        mem_stall;
   logic [31:0] mem_rdata;
   logic [3:0]  rmask_out;
   logic [3:0]  wmask_out;
   logic [31:0] dmem_address_out;
   logic [31:0] dmem_wdata_out;
   logic        misalign_trap;

   modport slave (
      input  valid_in, mem_read, mem_write, funct3, addr_in, store_data_in,
             advance, dmem_rdata, dmem_resp,
      output dmem_read, dmem_write, dmem_address, dmem_wmask, dmem_wdata,
             mem_stall, mem_rdata, rmask_out, wmask_out, dmem_address_out,
             dmem_wdata_out, misalign_trap
   );

   modport master (
      output valid_in, mem_read, mem_write, funct3, addr_in, store_data_in,
             advance, dmem_rdata, dmem_resp,
      input  dmem_read, dmem_write, dmem_address, dmem_wmask, dmem_wdata,
             mem_stall, mem_rdata, rmask_out, wmask_out, dmem_address_out,
             dmem_wdata_out, misalign_trap
   );
endinterface

// File: rtl/mem_access.sv
// MEM-stage data-access unit: word-aligned request generation, load formatting,
// store lane shifting and a one-transaction-per-instruction handshake FSM.
module mem_access (
   input  logic         clk,
   input  logic         rst,
   mem_access_if.slave  mem
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, HOLD = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [31:0] hold_q, hold_d;

   logic [1:0]  off;
   logic        is_mem;
   logic        misalign;
   logic        access;
   logic [3:0]  mask;
   logic [31:0] raw;
   logic [31:0] wdata;
   logic        req_en;

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] o,
                                            input logic [31:0] word);
      logic [31:0] b_lane;
      logic [31:0] h_lane;
      b_lane = word >> {o, 3'b000};
      h_lane = word >> {o[1], 4'b0000};
      case (f3)
         3'b000:  return {{24{b_lane[7]}}, b_lane[7:0]};
         3'b001:  return {{16{h_lane[15]}}, h_lane[15:0]};
         3'b100:  return {24'd0, b_lane[7:0]};
         3'b101:  return {16'd0, h_lane[15:0]};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] fmt_store(input logic [1:0] sz, input logic [1:0] o,
                                             input logic [31:0] data);
      case (sz)
         2'b00:   return data << {o, 3'b000};
         2'b01:   return data << {o[1], 4'b0000};
         default: return data;
      endcase
   endfunction

   assign off      = mem.addr_in[1:0];
   assign is_mem   = mem.valid_in & (mem.mem_read | mem.mem_write);
   assign misalign = is_mem & (((mem.funct3[1:0] == 2'b01) & off[0]) |
                               ((mem.funct3[1:0] == 2'b10) & (off != 2'b00)));
   assign access   = is_mem & ~misalign;

   always_comb begin
      mask = 4'b1111;
      case (mem.funct3[1:0])
         2'b00:   mask = 4'b0001 << off;
         2'b01:   mask = 4'b0011 << off;
         default: mask = 4'b1111;
      endcase
   end

   // HOLD replays the captured word so mem_rdata stays stable while the pipeline is held.
   assign raw   = (state_q == HOLD) ? hold_q : mem.dmem_rdata;
   assign wdata = fmt_store(mem.funct3[1:0], off, mem.store_data_in);

   assign req_en          = (state_q != HOLD) & access & ~rst;
   assign mem.dmem_read   = req_en & mem.mem_read;
   assign mem.dmem_write  = req_en & mem.mem_write;
   assign mem.mem_stall   = req_en & ~mem.dmem_resp;

   assign mem.dmem_address     = {mem.addr_in[31:2], 2'b00};
   assign mem.dmem_address_out = mem.dmem_address;
   assign mem.dmem_wdata       = wdata;
   assign mem.dmem_wdata_out   = wdata;
   assign mem.rmask_out        = (access & mem.mem_read)  ? mask : 4'b0000;
   assign mem.wmask_out        = (access & mem.mem_write) ? mask : 4'b0000;
   assign mem.dmem_wmask       = mem.wmask_out;
   assign mem.mem_rdata        = fmt_load(mem.funct3, off, raw);
   assign mem.misalign_trap    = misalign;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (mem.dmem_resp) begin
                  hold_d  = mem.dmem_rdata;
                  state_d = mem.advance ? IDLE : HOLD;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (mem.dmem_resp) begin
               hold_d  = mem.dmem_rdata;
               state_d = mem.advance ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (mem.advance) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: one task per scenario, inline checks.
module tb_mem_access;

   logic clk;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;

   mem_access_if m ();

   mem_access dut (
      .clk (clk),
      .rst (rst),
      .mem (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Completed handshakes: a strobe seen together with resp on a rising edge.
   always @(posedge clk) begin
      if (!rst && (m.dmem_read || m.dmem_write) && m.dmem_resp) txn <= txn + 1;
   end

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                        input logic resp, input logic adv);
      m.valid_in      = v;
      m.mem_read      = rd;
      m.mem_write     = wr;
      m.funct3        = f3;
      m.addr_in       = addr;
      m.store_data_in = sd;
      m.dmem_rdata    = rdata;
      m.dmem_resp     = resp;
      m.advance       = adv;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
      #1;
      checks++; if (m.dmem_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", m.dmem_read); end
      checks++; if (m.dmem_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", m.dmem_write); end
      checks++; if (m.mem_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", m.mem_stall); end
      checks++; if (m.mem_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", m.mem_rdata); end
      checks++; if (m.rmask_out !== 4'h0 || m.wmask_out !== 4'h0) begin failures++; $display("FAIL rst_masks got=%b/%b exp=0000/0000", m.rmask_out, m.wmask_out); end
      checks++; if (m.dmem_address !== 32'h0 || m.dmem_wdata_out !== 32'h0) begin failures++; $display("FAIL rst_addr_wdata got=%h/%h exp=0/0", m.dmem_address, m.dmem_wdata_out); end
      checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.state_q); end
      // A real load while rst is high must not raise any strobe or stall.
      drive(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);
      #1;
      checks++; if (m.dmem_read !== 1'b0 || m.mem_stall !== 1'b0) begin failures++; $display("FAIL rst_force got=%b/%b exp=0/0", m.dmem_read, m.mem_stall); end
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic test_lb_zero_wait();
      int t0;
      t0 = txn;
      @(negedge clk);
      drive(1, 1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 1);
      #1;
      checks++; if (m.dmem_address !== 32'h0000_1000) begin failures++; $display("FAIL lb_addr got=%h exp=00001000", m.dmem_address); end
      checks++; if (m.rmask_out !== 4'b1000) begin failures++; $display("FAIL lb_rmask got=%b exp=1000", m.rmask_out); end
      checks++; if (m.mem_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", m.mem_rdata); end
      checks++; if (m.mem_stall !== 1'b0 || m.dmem_read !== 1'b1) begin failures++; $display("FAIL lb_stall_read got=%b/%b exp=0/1", m.mem_stall, m.dmem_read); end
      checks++; if (m.wmask_out !== 4'b0000 || m.misalign_trap !== 1'b0) begin failures++; $display("FAIL lb_wmask_trap got=%b/%b exp=0000/0", m.wmask_out, m.misalign_trap); end
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
      #1;
      checks++; if (dut.state_q !== 2'd0 || txn - t0 != 1) begin failures++; $display("FAIL lb_done got=state%0d txn%0d exp=state0 txn1", dut.state_q, txn - t0); end
   endtask

   task automatic test_lhu_wait();
      int t0, stall_cnt, rd_cnt;
      t0 = txn; stall_cnt = 0; rd_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c < 3)       drive(1, 1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h0, 0, 0);
         else if (c == 3) drive(1, 1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 1, 1);
         else             drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
         #1;
         if (m.mem_stall) stall_cnt++;
         if (m.dmem_read) rd_cnt++;
         if (c == 3) begin
            checks++; if (m.mem_rdata !== 32'h0000_9ABC) begin failures++; $display("FAIL lhu_rdata got=%h exp=00009abc", m.mem_rdata); end
            checks++; if (m.rmask_out !== 4'b1100) begin failures++; $display("FAIL lhu_rmask got=%b exp=1100", m.rmask_out); end
         end
      end
      checks++; if (stall_cnt != 3) begin failures++; $display("FAIL lhu_stall_cycles got=%0d exp=3", stall_cnt); end
      checks++; if (rd_cnt != 4) begin failures++; $display("FAIL lhu_read_cycles got=%0d exp=4", rd_cnt); end
      checks++; if (txn - t0 != 1 || dut.state_q !== 2'd0) begin failures++; $display("FAIL lhu_done got=txn%0d state%0d exp=txn1 state0", txn - t0, dut.state_q); end
   endtask

   task automatic test_sb();
      @(negedge clk);
      drive(1, 0, 1, 3'b000, 32'h0000_0012, 32'h0000_00AB, 32'h0, 1, 1);
      #1;
      checks++; if (m.dmem_wmask !== 4'b0100 || m.wmask_out !== 4'b0100) begin failures++; $display("FAIL sb_wmask got=%b/%b exp=0100/0100", m.dmem_wmask, m.wmask_out); end
      checks++; if (m.dmem_wdata !== 32'h00AB_0000 || m.dmem_wdata_out !== 32'h00AB_0000) begin failures++; $display("FAIL sb_wdata got=%h/%h exp=00ab0000", m.dmem_wdata, m.dmem_wdata_out); end
      checks++; if (m.dmem_write !== 1'b1 || m.dmem_read !== 1'b0 || m.rmask_out !== 4'b0) begin failures++; $display("FAIL sb_strobes got=w%b r%b rm%b exp=w1 r0 rm0000", m.dmem_write, m.dmem_read, m.rmask_out); end
      checks++; if (m.dmem_address_out !== 32'h0000_0010) begin failures++; $display("FAIL sb_addr got=%h exp=00000010", m.dmem_address_out); end
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
      #1;
      checks++; if (m.dmem_write !== 1'b0) begin failures++; $display("FAIL sb_single_cycle got=%b exp=0", m.dmem_write); end
   endtask

   task automatic test_lw_hold();
      int t0;
      t0 = txn;
      @(negedge clk);
      drive(1, 1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h1122_3344, 1, 0);
      #1;
      checks++; if (m.mem_stall !== 1'b0 || m.mem_rdata !== 32'h1122_3344) begin failures++; $display("FAIL lw_resp got=stall%b %h exp=stall0 11223344", m.mem_stall, m.mem_rdata); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         drive(1, 1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 0, 0);
         #1;
         checks++; if (dut.state_q !== 2'd2) begin failures++; $display("FAIL lw_hold_state got=%0d exp=2", dut.state_q); end
         checks++; if (m.dmem_read !== 1'b0 || m.mem_stall !== 1'b0) begin failures++; $display("FAIL lw_hold_strobes got=%b/%b exp=0/0", m.dmem_read, m.mem_stall); end
         checks++; if (m.mem_rdata !== 32'h1122_3344) begin failures++; $display("FAIL lw_hold_rdata got=%h exp=11223344", m.mem_rdata); end
      end
      @(negedge clk);
      drive(1, 1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 0, 1);
      #1;
      checks++; if (m.mem_rdata !== 32'h1122_3344 || m.dmem_read !== 1'b0) begin failures++; $display("FAIL lw_adv_cycle got=%h rd%b exp=11223344 rd0", m.mem_rdata, m.dmem_read); end
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
      #1;
      checks++; if (dut.state_q !== 2'd0 || txn - t0 != 1) begin failures++; $display("FAIL lw_hold_done got=state%0d txn%0d exp=state0 txn1", dut.state_q, txn - t0); end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      drive(1, 0, 1, 3'b010, 32'h0000_0006, 32'hFFFF_FFFF, 32'h0, 0, 1);
      #1;
      checks++; if (m.misalign_trap !== 1'b1) begin failures++; $display("FAIL sw_trap got=%b exp=1", m.misalign_trap); end
      checks++; if (m.dmem_write !== 1'b0 || m.dmem_read !== 1'b0 || m.mem_stall !== 1'b0) begin failures++; $display("FAIL sw_quiet got=w%b r%b s%b exp=000", m.dmem_write, m.dmem_read, m.mem_stall); end
      checks++; if (m.wmask_out !== 4'b0 || m.dmem_wmask !== 4'b0) begin failures++; $display("FAIL sw_wmask got=%b/%b exp=0000", m.wmask_out, m.dmem_wmask); end
      @(negedge clk);
      drive(1, 1, 0, 3'b001, 32'h0000_0005, 32'h0, 32'h0, 0, 1);
      #1;
      checks++; if (m.misalign_trap !== 1'b1 || m.dmem_read !== 1'b0 || m.rmask_out !== 4'b0) begin failures++; $display("FAIL lh_trap got=t%b r%b rm%b exp=t1 r0 rm0000", m.misalign_trap, m.dmem_read, m.rmask_out); end
      checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL misalign_state got=%0d exp=0", dut.state_q); end
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
   endtask

   task automatic test_formats();
      logic [2:0]  lf3 [0:3];
      logic [31:0] laddr [0:3];
      logic [31:0] lexp [0:3];
      logic [3:0]  lmask [0:3];
      logic [2:0]  sf3 [0:2];
      logic [31:0] saddr [0:2];
      logic [31:0] sdat [0:2];
      logic [31:0] sexp [0:2];
      logic [3:0]  smask [0:2];
      lf3[0] = 3'b100; laddr[0] = 32'h1003; lexp[0] = 32'h0000_0080; lmask[0] = 4'b1000;
      lf3[1] = 3'b001; laddr[1] = 32'h1002; lexp[1] = 32'hFFFF_80FF; lmask[1] = 4'b1100;
      lf3[2] = 3'b001; laddr[2] = 32'h1000; lexp[2] = 32'h0000_1234; lmask[2] = 4'b0011;
      lf3[3] = 3'b010; laddr[3] = 32'h1000; lexp[3] = 32'h80FF_1234; lmask[3] = 4'b1111;
      sf3[0] = 3'b001; saddr[0] = 32'h22; sdat[0] = 32'h0000_1234; sexp[0] = 32'h1234_0000; smask[0] = 4'b1100;
      sf3[1] = 3'b010; saddr[1] = 32'h20; sdat[1] = 32'hCAFE_F00D; sexp[1] = 32'hCAFE_F00D; smask[1] = 4'b1111;
      sf3[2] = 3'b000; saddr[2] = 32'h21; sdat[2] = 32'h0000_00AB; sexp[2] = 32'h0000_AB00; smask[2] = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 1, 0, lf3[i], laddr[i], 32'h0, 32'h80FF_1234, 1, 1);
         #1;
         checks++; if (m.mem_rdata !== lexp[i] || m.rmask_out !== lmask[i]) begin failures++; $display("FAIL load_fmt%0d got=%h/%b exp=%h/%b", i, m.mem_rdata, m.rmask_out, lexp[i], lmask[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1, 0, 1, sf3[i], saddr[i], sdat[i], 32'h0, 1, 1);
         #1;
         checks++; if (m.dmem_wdata !== sexp[i] || m.dmem_wmask !== smask[i]) begin failures++; $display("FAIL store_fmt%0d got=%h/%b exp=%h/%b", i, m.dmem_wdata, m.dmem_wmask, sexp[i], smask[i]); end
      end
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
   endtask

   task automatic test_rst_mid_access();
      int t0;
      @(negedge clk);
      drive(1, 1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 0);
      #1;
      checks++; if (m.dmem_read !== 1'b1 || m.mem_stall !== 1'b1) begin failures++; $display("FAIL rstm_req got=%b/%b exp=1/1", m.dmem_read, m.mem_stall); end
      @(negedge clk);
      #1;
      checks++; if (dut.state_q !== 2'd1) begin failures++; $display("FAIL rstm_access_state got=%0d exp=1", dut.state_q); end
      #2 rst = 1'b1;
      #1;
      checks++; if (m.dmem_read !== 1'b0 || m.mem_stall !== 1'b0 || dut.state_q !== 2'd0) begin failures++; $display("FAIL rstm_async got=r%b s%b state%0d exp=r0 s0 state0", m.dmem_read, m.mem_stall, dut.state_q); end
      @(negedge clk);
      rst = 1'b0;
      t0 = txn;
      #1;
      checks++; if (m.dmem_read !== 1'b1 || m.mem_stall !== 1'b1) begin failures++; $display("FAIL rstm_reissue got=%b/%b exp=1/1", m.dmem_read, m.mem_stall); end
      @(negedge clk);
      drive(1, 1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h5566_7788, 1, 1);
      #1;
      checks++; if (m.mem_stall !== 1'b0 || m.mem_rdata !== 32'h5566_7788) begin failures++; $display("FAIL rstm_resp got=s%b %h exp=s0 55667788", m.mem_stall, m.mem_rdata); end
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
      #1;
      checks++; if (dut.state_q !== 2'd0 || txn - t0 != 1) begin failures++; $display("FAIL rstm_done got=state%0d txn%0d exp=state0 txn1", dut.state_q, txn - t0); end
   endtask

   task automatic test_resp_no_request();
      @(negedge clk);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 1, 0);
      #1;
      checks++; if (m.dmem_read !== 1'b0 || m.mem_stall !== 1'b0) begin failures++; $display("FAIL stray_resp_out got=%b/%b exp=0/0", m.dmem_read, m.mem_stall); end
      @(negedge clk);
      #1;
      checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL stray_resp_state got=%0d exp=0", dut.state_q); end
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_lb_zero_wait();
      test_lhu_wait();
      test_sb();
      test_lw_hold();
      test_misalign();
      test_formats();
      test_rst_mid_access();
      test_resp_no_request();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
